frodo_seq: RTL and testbench
============================

FRODO_SEQ -- requirements
Module: frodo_seq

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width.
REQ-002 SHALL have parameter NUM_MODES, default 4, number of mode table entries; mode index width MODE_W = clog2(NUM_MODES).
REQ-003 SHALL have parameter LEVEL_W, default 2, security-level width.
REQ-004 SHALL have parameter TIMEOUT, default 1024, maximum EX cycles per instruction.
REQ-005 SHALL have ports:
  clk  in  1  clock
  rstn  in  1  asynchronous active-low reset
  level  in  LEVEL_W  requested security level
  mode  in  MODE_W  requested operation (0 keygen, 1 encap, 2 decap)
  start  in  1  run request, rising-edge sensitive
  abort  in  1  terminate current run
  inst_done  in  1  executing instruction complete
  cfg_we  in  1  program-table write strobe
  cfg_mode  in  MODE_W  table entry written
  cfg_base  in  PC_W  first pc of that mode
  cfg_last  in  PC_W  last pc of that mode
  valid  out  1  run completed (one-cycle pulse)
  err  out  1  instruction timeout (one-cycle pulse)
  busy  out  1  state not IDLE
  inst_valid  out  1  fetch strobe for pc
  level_reg  out  LEVEL_W  latched level
  pc  out  PC_W  current instruction address

Function
REQ-006 SHALL detect start_pos = start & ~start_q, with start_q registered every cycle.
REQ-007 SHALL implement states IDLE, START, IF, EX, FIN.
REQ-008 IDLE: go to START on start_pos, else stay; latch level_reg/mode_reg every IDLE cycle; pc <= 0.
REQ-009 START: pc <= base[mode_reg]; go to IF.
REQ-010 IF: inst_valid = 1 for exactly this cycle; go to EX.
REQ-011 EX: go to FIN on inst_done, else stay; inst_done outside EX SHALL be ignored.
REQ-012 FIN: if pc == last[mode_reg], assert valid combinationally this cycle and go to IDLE; else pc <= pc + 1 (modulo 2^PC_W) and go to IF.
REQ-013 Run length SHALL be (last - base) mod 2^PC_W + 1 instructions; base > last wraps through 0.
REQ-014 abort in any non-IDLE state SHALL force IDLE next cycle with no valid or err; abort wins over simultaneous inst_done or timeout.
REQ-015 start_pos in non-IDLE states SHALL be ignored.
REQ-016 cfg_we SHALL write base/last[cfg_mode] only while IDLE and not start_pos; otherwise dropped; cfg_mode >= NUM_MODES dropped.
REQ-017 A table write SHALL take effect for any run whose START cycle follows the write cycle.
REQ-018 busy = (state != IDLE), combinational.

Reset
REQ-019 On rstn low: state IDLE, pc 0, level_reg 0, mode_reg 0, start_q 0, timeout counter 0; valid, err, inst_valid 0.
REQ-020 Table reset values SHALL be base[m] = 0 and last[m] = 5 + m (keygen 5, encap 6, decap 7).
REQ-021 Reset mid-run SHALL discard the run with no valid pulse.

Configuration
REQ-022 With FRODO_SEQ_TIMEOUT_EN defined: a counter SHALL clear on entering EX, increment each EX cycle, and when it reaches TIMEOUT-1 without inst_done SHALL pulse err for one cycle and force IDLE next.
REQ-023 Without FRODO_SEQ_TIMEOUT_EN: no counter, err tied 0, EX waits indefinitely.

Structure
REQ-024 State encodings, mode constants (KEYGEN, ENCAP, DECAP) and table reset defaults SHALL reside in shared package frodo_seq_pkg.
REQ-025 The base/last table SHALL be sub-module frodo_seq_table (write port, combinational read by mode_reg).

Verification
REQ-026 Reset defaults, mode=0, start rising, inst_done 2 cycles after each inst_valid -> pc 0..5, six inst_valid pulses, valid with pc=5, then IDLE.
REQ-027 Write mode 1 base=250 last=3 in IDLE, run mode 1 -> pc 250..255,0..3, ten instructions, valid at pc=3.
REQ-028 Run mode 2, assert abort together with inst_done at pc=4 -> IDLE next cycle, no valid, pc 0.
REQ-029 With FRODO_SEQ_TIMEOUT_EN, TIMEOUT=16, inst_done never asserted -> err pulse on 16th EX cycle, IDLE next; without macro busy stays 1.
REQ-030 Hold start high across run end, pulse cfg_we while busy -> no restart, table unchanged; rstn low at pc=3 -> all outputs 0 immediately.

Source files
------------

// File: rtl/frodo_seq_pkg.sv
// Shared constants for the FrodoKEM instruction sequencer: FSM encodings, operation
// modes and program-table reset defaults.
package frodo_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StStart = 3'd1;
  localparam state_t StIf    = 3'd2;
  localparam state_t StEx    = 3'd3;
  localparam state_t StFin   = 3'd4;

  localparam int unsigned KEYGEN = 0;
  localparam int unsigned ENCAP  = 1;
  localparam int unsigned DECAP  = 2;

  localparam int unsigned DefaultBase       = 0;
  localparam int unsigned DefaultLastOffset = 5;

  function automatic int unsigned default_last(input int unsigned m);
    return DefaultLastOffset + m;
  endfunction

  // Index width with a 1-bit floor so single-entry configurations stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frodo_seq_if.sv
// Request/config/status bundle between a host and the frodo_seq sequencer.
interface frodo_seq_if #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned MODE_W  = 2,
  parameter int unsigned LEVEL_W = 2
);
  logic [LEVEL_W-1:0] level;
  logic [MODE_W-1:0]  mode;
  logic               start;
  logic               abort;
  logic               inst_done;
  logic               cfg_we;
  logic [MODE_W-1:0]  cfg_mode;
  logic [PC_W-1:0]    cfg_base;
  logic [PC_W-1:0]    cfg_last;
  logic               valid;
  logic               err;
  logic               busy;
  logic               inst_valid;
  logic [LEVEL_W-1:0] level_reg;
  logic [PC_W-1:0]    pc;

  modport master (
    output level, mode, start, abort, inst_done, cfg_we, cfg_mode, cfg_base, cfg_last,
    input  valid, err, busy, inst_valid, level_reg, pc
  );

  modport slave (
    input  level, mode, start, abort, inst_done, cfg_we, cfg_mode, cfg_base, cfg_last,
    output valid, err, busy, inst_valid, level_reg, pc
  );
endinterface

// File: rtl/frodo_seq_table.sv
// Per-mode program range table (first/last pc), one write port and a combinational
// read port; entries reset to the package defaults.
module frodo_seq_table
  import frodo_seq_pkg::*;
#(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned NUM_MODES = 4,
  parameter int unsigned MODE_W    = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [MODE_W-1:0] wmode,
  input  logic [PC_W-1:0]   wbase,
  input  logic [PC_W-1:0]   wlast,
  input  logic [MODE_W-1:0] rmode,
  output logic [PC_W-1:0]   base,
  output logic [PC_W-1:0]   last
);

  logic [PC_W-1:0] base_q [NUM_MODES];
  logic [PC_W-1:0] last_q [NUM_MODES];

  // Address decode per entry; writes to a mode index with no entry hit nothing.
  for (genvar g = 0; g < NUM_MODES; g++) begin : g_entry
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        base_q[g] <= PC_W'(DefaultBase);
        last_q[g] <= PC_W'(default_last(g));
      end else if (we && (wmode == MODE_W'(g))) begin
        base_q[g] <= wbase;
        last_q[g] <= wlast;
      end
    end
  end

  always_comb begin
    base = '0;
    last = '0;
    if (32'(rmode) < NUM_MODES) begin
      base = base_q[rmode];
      last = last_q[rmode];
    end
  end

endmodule

// File: rtl/frodo_seq.sv
// FrodoKEM instruction sequencer: walks pc from base to last of the selected mode.
// Optional per-instruction timeout enabled by defining FRODO_SEQ_TIMEOUT_EN.
module frodo_seq
  import frodo_seq_pkg::*;
#(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned NUM_MODES = 4,
  parameter int unsigned LEVEL_W   = 2,
  parameter int unsigned TIMEOUT   = 1024
) (
  input logic        clk,
  input logic        rstn,
  frodo_seq_if.slave bus
);

  localparam int unsigned MODE_W = idx_width(NUM_MODES);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [LEVEL_W-1:0] level_q;
  logic [MODE_W-1:0]  mode_q;
  logic               start_q;
  logic               start_pos;
  logic               tbl_we;
  logic [PC_W-1:0]    tbl_base, tbl_last;
  logic               tmo_hit;
  logic               valid, err;

  assign start_pos = bus.start & ~start_q;
  // A write racing a run launch is dropped so the run sees a stable table.
  assign tbl_we    = bus.cfg_we && (state_q == StIdle) && !start_pos;

  frodo_seq_table #(
    .PC_W      (PC_W),
    .NUM_MODES (NUM_MODES),
    .MODE_W    (MODE_W)
  ) u_table (
    .clk   (clk),
    .rstn  (rstn),
    .we    (tbl_we),
    .wmode (bus.cfg_mode),
    .wbase (bus.cfg_base),
    .wlast (bus.cfg_last),
    .rmode (mode_q),
    .base  (tbl_base),
    .last  (tbl_last)
  );

`ifdef FRODO_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = idx_width(TIMEOUT);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q == StEx) && (tmo_q == TMO_W'(TIMEOUT - 1));

  // Held at zero outside EX, so the count restarts on every EX entry.
  always_comb begin
    tmo_d = '0;
    if (state_q == StEx) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid   = 1'b0;
    err     = 1'b0;
    case (state_q)
      StIdle: begin
        pc_d = '0;
        if (start_pos) state_d = StStart;
      end
      StStart: begin
        pc_d    = tbl_base;
        state_d = StIf;
      end
      StIf: state_d = StEx;
      StEx: begin
        if (bus.inst_done) begin
          state_d = StFin;
        end else if (tmo_hit) begin
          err     = 1'b1;
          state_d = StIdle;
        end
      end
      StFin: begin
        if (pc_q == tbl_last) begin
          valid   = 1'b1;
          state_d = StIdle;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = StIf;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort overrides completion and timeout alike.
    if (bus.abort && (state_q != StIdle)) begin
      state_d = StIdle;
      pc_d    = '0;
      valid   = 1'b0;
      err     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      pc_q    <= '0;
      level_q <= '0;
      mode_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      start_q <= bus.start;
      if (state_q == StIdle) begin
        level_q <= bus.level;
        mode_q  <= bus.mode;
      end
    end
  end

  assign bus.valid      = valid;
  assign bus.err        = err;
  assign bus.busy       = (state_q != StIdle);
  assign bus.inst_valid = (state_q == StIf);
  assign bus.level_reg  = level_q;
  assign bus.pc         = pc_q;

endmodule

// File: tb/tb_frodo_seq.sv
// Self-checking bench for frodo_seq: table-driven runs plus abort, timeout, held-start,
// busy config write and mid-run reset sequences.
module tb_frodo_seq;
  import frodo_seq_pkg::*;

  localparam int unsigned PC_W      = 8;
  localparam int unsigned NUM_MODES = 4;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned LEVEL_W   = 2;
  localparam int unsigned TIMEOUT   = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  frodo_seq_if #(.PC_W(PC_W), .MODE_W(MODE_W), .LEVEL_W(LEVEL_W)) bus ();

  frodo_seq #(
    .PC_W      (PC_W),
    .NUM_MODES (NUM_MODES),
    .LEVEL_W   (LEVEL_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  int unsigned m_base [NUM_MODES];
  int unsigned m_last [NUM_MODES];
  int unsigned exp_pc_q [$];

  typedef struct {
    int mode;
    int lvl;
    bit wr;
    int wbase;
    int wlast;
    int exp_n;
    int exp_last;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic write_cfg(input int m, input int b, input int l);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_mode = MODE_W'(m);
    bus.cfg_base = PC_W'(b);
    bus.cfg_last = PC_W'(l);
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  // cfg_when: 0 none, 1 write alongside the start edge, 2 write while busy.
  task automatic run(input int m, input int lvl, input int abort_idx, input int rst_pc,
                     input bit hold_start, input int cfg_when,
                     output int n_iv, output int n_val, output int n_err,
                     output int val_pc, output int lvl_seen);
    int  cnt;
    int  len;
    bit  started;
    bit  finished;
    bit  early;
    n_iv = 0; n_val = 0; n_err = 0; val_pc = -1; lvl_seen = -1;
    cnt = 0; started = 0; finished = 0; early = 0;
    exp_pc_q.delete();
    len = int'((m_last[m] - m_base[m]) & 32'hFF) + 1;
    for (int i = 0; i < len; i++) exp_pc_q.push_back((m_base[m] + i) & 32'hFF);
    bus.mode  = MODE_W'(m);
    bus.level = LEVEL_W'(lvl);
    bus.start = 1'b1;
    if (cfg_when == 1) begin
      bus.cfg_we = 1'b1; bus.cfg_mode = MODE_W'(m);
      bus.cfg_base = 8'd100; bus.cfg_last = 8'd101;
    end
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      if (!hold_start) bus.start = 1'b0;
      bus.level  = LEVEL_W'(~lvl);
      bus.cfg_we = 1'b0;
      if (bus.abort) begin
        check("abort_busy", bus.busy, 0);
        check("abort_pc", bus.pc, 0);
        check("abort_valid", bus.valid, 0);
        bus.abort = 1'b0;
        finished = 1; early = 1;
      end else if (!bus.busy && started) begin
        finished = 1;
      end else begin
        if (bus.busy) started = 1;
        if (cfg_when == 2 && cyc == 3) begin
          bus.cfg_we = 1'b1; bus.cfg_mode = MODE_W'(m);
          bus.cfg_base = 8'd100; bus.cfg_last = 8'd101;
        end
        if (bus.valid) begin
          n_val++; val_pc = int'(bus.pc); lvl_seen = int'(bus.level_reg);
        end
        if (bus.err) n_err++;
        bus.inst_done = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.inst_done = 1'b1;
            if (n_iv - 1 == abort_idx) bus.abort = 1'b1;
          end
        end
        if (bus.inst_valid) begin
          n_iv++;
          if (exp_pc_q.size() == 0) check("extra_fetch", n_iv, len);
          else check("fetch_pc", bus.pc, exp_pc_q.pop_front());
          cnt = 2;
          if (int'(bus.pc) == rst_pc) begin
            rstn = 1'b0;
            #1;
            check("rst_busy", bus.busy, 0);
            check("rst_pc", bus.pc, 0);
            check("rst_inst_valid", bus.inst_valid, 0);
            check("rst_valid", bus.valid, 0);
            check("rst_err", bus.err, 0);
            check("rst_level_reg", bus.level_reg, 0);
            finished = 1; early = 1;
          end
        end
      end
    end
    if (!finished) check("run_ends", finished, 1);
    if (!early) check("fetch_left", exp_pc_q.size(), 0);
    bus.inst_done = 1'b0;
    bus.abort     = 1'b0;
  endtask

  int n_iv, n_val, n_err, val_pc, lvl_seen, k;

  initial begin
    vecs[0] = '{mode: 0, lvl: 1, wr: 0, wbase: 0,   wlast: 0,  exp_n: 6,  exp_last: 5};
    vecs[1] = '{mode: 1, lvl: 2, wr: 1, wbase: 250, wlast: 3,  exp_n: 10, exp_last: 3};
    vecs[2] = '{mode: 2, lvl: 2, wr: 0, wbase: 0,   wlast: 0,  exp_n: 8,  exp_last: 7};
    vecs[3] = '{mode: 3, lvl: 3, wr: 1, wbase: 10,  wlast: 10, exp_n: 1,  exp_last: 10};
    vecs[4] = '{mode: 1, lvl: 0, wr: 0, wbase: 0,   wlast: 0,  exp_n: 10, exp_last: 3};
    vecs[5] = '{mode: 0, lvl: 1, wr: 1, wbase: 255, wlast: 0,  exp_n: 2,  exp_last: 0};

    bus.level = '0; bus.mode = '0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.inst_done = 1'b0; bus.cfg_we = 1'b0; bus.cfg_mode = '0;
    bus.cfg_base = '0; bus.cfg_last = '0;
    for (int m = 0; m < int'(NUM_MODES); m++) begin
      m_base[m] = 0;
      m_last[m] = 5 + m;
    end

    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_pc", bus.pc, 0);
    check("reset_level_reg", bus.level_reg, 0);
    check("reset_valid", bus.valid, 0);
    check("reset_err", bus.err, 0);
    check("reset_inst_valid", bus.inst_valid, 0);
    rstn = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        write_cfg(vecs[i].mode, vecs[i].wbase, vecs[i].wlast);
        m_base[vecs[i].mode] = vecs[i].wbase;
        m_last[vecs[i].mode] = vecs[i].wlast;
      end
      run(vecs[i].mode, vecs[i].lvl, -1, -1, 0, 0, n_iv, n_val, n_err, val_pc, lvl_seen);
      check("vec_fetches", n_iv, vecs[i].exp_n);
      check("vec_valid_cnt", n_val, 1);
      check("vec_valid_pc", val_pc, vecs[i].exp_last);
      check("vec_level_reg", lvl_seen, vecs[i].lvl);
      check("vec_err_cnt", n_err, 0);
      @(negedge clk);
    end

    // Abort together with inst_done at pc 4 of a decap run.
    run(2, 1, 4, -1, 0, 0, n_iv, n_val, n_err, val_pc, lvl_seen);
    check("abort_fetches", n_iv, 5);
    check("abort_valid_cnt", n_val, 0);
    check("abort_err_cnt", n_err, 0);
    @(negedge clk);

    // inst_done never arrives.
    bus.mode = MODE_W'(2); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!bus.inst_valid && k < 10) begin @(negedge clk); k++; end
    check("tmo_fetch_seen", bus.inst_valid, 1);
    k = 0; n_err = 0;
`ifdef FRODO_SEQ_TIMEOUT_EN
    while (k < 40 && n_err == 0) begin
      @(negedge clk);
      k++;
      if (bus.err) n_err++;
    end
    check("tmo_ex_cycles", k, 16);
    @(negedge clk);
    check("tmo_idle", bus.busy, 0);
    check("tmo_err_once", bus.err, 0);
`else
    repeat (40) begin
      @(negedge clk);
      if (bus.err) n_err++;
    end
    check("notmo_busy", bus.busy, 1);
    check("notmo_err_cnt", n_err, 0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("notmo_abort_idle", bus.busy, 0);
`endif
    @(negedge clk);

    // Start held high across the end of a run, config write attempted while busy.
    run(2, 2, -1, -1, 1, 2, n_iv, n_val, n_err, val_pc, lvl_seen);
    check("hold_fetches", n_iv, 8);
    check("hold_valid_pc", val_pc, 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_no_restart", bus.busy, 0);
    end
    bus.start = 1'b0;
    @(negedge clk);
    run(2, 0, -1, -1, 0, 0, n_iv, n_val, n_err, val_pc, lvl_seen);
    check("busywr_fetches", n_iv, 8);
    check("busywr_valid_pc", val_pc, 7);
    @(negedge clk);

    // Config write on the same cycle as the start edge is dropped.
    run(3, 1, -1, -1, 0, 1, n_iv, n_val, n_err, val_pc, lvl_seen);
    check("startwr_fetches", n_iv, 1);
    check("startwr_valid_pc", val_pc, 10);
    @(negedge clk);
    run(3, 1, -1, -1, 0, 0, n_iv, n_val, n_err, val_pc, lvl_seen);
    check("startwr_kept_pc", val_pc, 10);
    @(negedge clk);

    // Reset at pc 3 discards the run and restores the table defaults.
    run(2, 3, -1, 3, 0, 0, n_iv, n_val, n_err, val_pc, lvl_seen);
    check("rst_valid_cnt", n_val, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    n_val = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.valid || bus.busy) n_val++;
    end
    check("rst_quiet", n_val, 0);
    for (int m = 0; m < int'(NUM_MODES); m++) begin
      m_base[m] = 0;
      m_last[m] = 5 + m;
    end
    run(1, 2, -1, -1, 0, 0, n_iv, n_val, n_err, val_pc, lvl_seen);
    check("rst_default_fetches", n_iv, 7);
    check("rst_default_pc", val_pc, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
